odd_multiple_mac: RTL

- Consumes the shifter stage's decomposition of a 4-bit coefficient: odd part select (select_line), power-of-two shift (i_shifter_count) and zero flag.
- Forms coefficient x data as (2*select_line+1)*data << shift, using an odd-multiple table built sequentially from the input sample.
- Accumulates NUM_TAPS such products into one filter output sample. Sits directly downstream of the shifter in the FIR datapath, sharing its in_data_vld.

---
 rtl/odd_multiple_mac_pkg.sv | 26 ++
 rtl/odd_multiple_table.sv | 54 +++++
 rtl/odd_multiple_mac.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/odd_multiple_mac_pkg.sv
// Shared FIR datapath types and width helpers for the odd-multiple MAC.
// Latency: none (package only).
// Backpressure: none (package only).
package fir_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int NUM_TAPS_DEF = 4;
    localparam int N_ODD        = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        READY = 2'd2
    } state_t;

    // A 4-bit coefficient is at most 15, so a product needs 4 bits over the sample.
    function automatic int prod_width(input int data_w);
        return data_w + 4;
    endfunction

    // Summing num_taps products grows the sum by clog2(num_taps) bits.
    function automatic int acc_width(input int data_w, input int num_taps);
        return prod_width(data_w) + $clog2(num_taps);
    endfunction

endpackage

// File: rtl/odd_multiple_table.sv
// Builds the odd-multiple table {1x,3x,...,15x} of a sample and serves reads by index.
// Latency: start at edge 0, table[7] written at edge 7; done is high in the cycle before that edge.
// Backpressure: none; start must only be raised while no build is in progress.
module odd_multiple_table
    import fir_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PROD_W = prod_width(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] start_data,
    input  logic [2:0]        rd_idx,
    output logic              done,
    output logic [PROD_W-1:0] rd_dat
);

    logic [PROD_W-1:0] tbl [N_ODD];
    logic [PROD_W-1:0] twox;
    logic [PROD_W-1:0] start_ext;
    logic [2:0]        k;
    logic              building;

    assign start_ext = {{(PROD_W-DATA_W){1'b0}}, start_data};

    // done flags the build step that writes the last entry.
    assign done   = building && (k == 3'd7);
    assign rd_dat = tbl[rd_idx];

    // Seed entry 0 with x, then add 2x per cycle to walk through the odd multiples.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_ODD; i++) begin
                tbl[i] <= '0;
            end
            twox     <= '0;
            k        <= '0;
            building <= 1'b0;
        end else if (start) begin
            tbl[0]   <= start_ext;
            twox     <= start_ext << 1;
            k        <= 3'd1;
            building <= 1'b1;
        end else if (building) begin
            tbl[k] <= tbl[k - 3'd1] + twox;
            k      <= k + 3'd1;
            if (done) begin
                building <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/odd_multiple_mac.sv
// Multiplies a sample by a shifter-decomposed coefficient and sums NUM_TAPS products.
// Latency: product_vld 8 cycles after an accepted in_data_vld when the shifter result is on time.
// Backpressure: none; strobes arriving while busy or while a result is already pending pulse drop_err.
module odd_multiple_mac
    import fir_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_TAPS = NUM_TAPS_DEF,
    parameter int PROD_W   = prod_width(DATA_W),
    parameter int ACC_W    = acc_width(DATA_W, NUM_TAPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_data_vld,
    input  logic [2:0]        select_line,
    input  logic              select_line_vld,
    input  logic [1:0]        i_shifter_count,
    input  logic              polynomial_zero,
    output logic              busy,
    output logic [PROD_W-1:0] product,
    output logic              product_vld,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_vld,
    output logic              drop_err
);

    localparam int               TAP_W    = $clog2(NUM_TAPS);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              issue;
    logic              drop_nxt;

    logic              pend_vld;
    logic [2:0]        pend_sel;
    logic [1:0]        pend_shift;
    logic              pend_zero;

    logic [2:0]        src_sel;
    logic [1:0]        src_shift;
    logic              src_zero;

    logic              tbl_done;
    logic [PROD_W-1:0] tbl_dat;
    logic [PROD_W-1:0] prod_nxt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [TAP_W-1:0]  tap_cnt;

    odd_multiple_table #(
        .DATA_W (DATA_W),
        .PROD_W (PROD_W)
    ) u_table (
        .clk        (clk),
        .reset      (reset),
        .start      (accept),
        .start_data (in_data),
        .rd_idx     (src_sel),
        .done       (tbl_done),
        .rd_dat     (tbl_dat)
    );

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept a sample, build its table, then wait for a coefficient.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_data_vld) state_nxt = BUILD;
            BUILD:   if (tbl_done)    state_nxt = READY;
            READY:   if (issue)       state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control decode: sample accept, product issue and ignored-strobe detection.
    always_comb begin
        accept   = (state == IDLE) && in_data_vld;
        issue    = (state == READY) && (pend_vld || select_line_vld);
        drop_nxt = (in_data_vld && (state != IDLE)) ||
                   (select_line_vld && ((state == IDLE) || pend_vld));
    end

    // A coefficient captured early wins over a live one arriving in READY.
    always_comb begin
        src_sel   = pend_vld ? pend_sel   : select_line;
        src_shift = pend_vld ? pend_shift : i_shifter_count;
        src_zero  = pend_vld ? pend_zero  : polynomial_zero;
        prod_nxt  = src_zero ? '0 : (tbl_dat << src_shift);
        acc_sum   = acc + ACC_W'(prod_nxt);
    end

    // Pending coefficient register: latest strobe during a build overwrites the older one.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_vld   <= 1'b0;
            pend_sel   <= '0;
            pend_shift <= '0;
            pend_zero  <= 1'b0;
        end else if (issue) begin
            pend_vld <= 1'b0;
        end else if ((state != IDLE) && select_line_vld) begin
            pend_vld   <= 1'b1;
            pend_sel   <= select_line;
            pend_shift <= i_shifter_count;
            pend_zero  <= polynomial_zero;
        end
    end

    // Product issue and tap accumulation; acc_out lands with the last tap's product.
    always_ff @(posedge clk) begin
        if (reset) begin
            product     <= '0;
            product_vld <= 1'b0;
            acc_out     <= '0;
            acc_vld     <= 1'b0;
            acc         <= '0;
            tap_cnt     <= '0;
            drop_err    <= 1'b0;
        end else begin
            product_vld <= 1'b0;
            acc_vld     <= 1'b0;
            drop_err    <= drop_nxt;
            if (issue) begin
                product     <= prod_nxt;
                product_vld <= 1'b1;
                if (tap_cnt != LAST_TAP) begin
                    acc     <= acc_sum;
                    tap_cnt <= tap_cnt + 1'b1;
                end else begin
                    acc_out <= acc_sum;
                    acc_vld <= 1'b1;
                    acc     <= '0;
                    tap_cnt <= '0;
                end
            end
        end
    end

endmodule
